step_position_ctrl: RTL and testbench

Move sequencer that sits directly upstream of the stepper phase driver. It accepts signed relative move commands over a valid/ready handshake and emits single-cycle step strobes at a programmable cycle period, together with a stable direction level. It also tracks absolute position and reports completion or abort. The phase driver consumes `step` as its advance enable and `dir` as its direction, all in the single `clk` domain.

---
 rtl/step_position_ctrl.sv | 137 +++++++++++++
 tb/tb_step_position_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/step_position_ctrl.sv
// Step sequencer: turns signed relative move commands into periodic single-cycle
// step strobes with a stable direction level, and tracks absolute position.
module step_position_ctrl #(
    parameter int COUNT_W  = 16,
    parameter int PERIOD_W = 24,
    parameter int POS_W    = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic signed [COUNT_W-1:0]  cmd_steps,
    input  logic        [PERIOD_W-1:0] cmd_period,
    input  logic                       abort,
    input  logic                       pos_clear,
    output logic                       step,
    output logic                       dir,
    output logic                       busy,
    output logic                       done,
    output logic                       aborted,
    output logic signed [POS_W-1:0]    position,
    output logic        [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [PERIOD_W-1:0] PERIOD_ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};
    localparam logic [PERIOD_W-1:0] PERIOD_TWO = {{(PERIOD_W-2){1'b0}}, 2'b10};
    localparam logic [COUNT_W-1:0]  COUNT_ONE  = {{(COUNT_W-1){1'b0}}, 1'b1};
    localparam logic [POS_W-1:0]    POS_ONE    = {{(POS_W-1){1'b0}}, 1'b1};

    state_t                     state_q;
    logic [COUNT_W-1:0]         remaining_q;
    logic [PERIOD_W-1:0]        timer_q;
    logic [PERIOD_W-1:0]        reload_q;
    logic                       step_q;
    logic                       dir_q;
    logic                       busy_q;
    logic                       done_q;
    logic                       aborted_q;
    logic signed [POS_W-1:0]    position_q;

    logic                       accept;
    logic [COUNT_W-1:0]         cmd_mag;
    logic [PERIOD_W-1:0]        cmd_reload;

    // Handshake: a command transfers on a rising edge where cmd_valid and
    // cmd_ready are both high; cmd_ready never depends on cmd_valid.
    assign cmd_ready = (state_q == IDLE) && !abort && !rst;
    assign accept    = cmd_valid && cmd_ready;

    // Negating the most negative count wraps to the same bit pattern, which
    // read as unsigned is exactly its magnitude.
    assign cmd_mag    = cmd_steps[COUNT_W-1] ? -cmd_steps : cmd_steps;
    assign cmd_reload = (cmd_period < PERIOD_TWO) ? PERIOD_ONE : (cmd_period - PERIOD_ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            timer_q     <= '0;
            reload_q    <= '0;
            step_q      <= 1'b0;
            dir_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            aborted_q   <= 1'b0;
            position_q  <= '0;
        end else begin
            step_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pos_clear) begin
                        position_q <= '0;
                    end
                    if (accept) begin
                        busy_q <= 1'b1;
                        if (cmd_steps == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            remaining_q <= cmd_mag;
                            dir_q       <= ~cmd_steps[COUNT_W-1];
                            reload_q    <= cmd_reload;
                            timer_q     <= cmd_reload;
                            state_q     <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        aborted_q <= 1'b1;
                    end else if (timer_q == '0) begin
                        step_q      <= 1'b1;
                        position_q  <= dir_q ? (position_q + POS_ONE) : (position_q - POS_ONE);
                        remaining_q <= remaining_q - COUNT_ONE;
                        timer_q     <= reload_q;
                        if (remaining_q == COUNT_ONE) begin
                            state_q <= DONE;
                        end
                    end else begin
                        timer_q <= timer_q - PERIOD_ONE;
                    end
                end
                DONE: begin
                    // After a final step, DONE holds one cycle so done trails the last strobe.
                    if (done_q) begin
                        done_q    <= 1'b0;
                        aborted_q <= 1'b0;
                        busy_q    <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign step      = step_q;
    assign dir       = dir_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign aborted   = aborted_q;
    assign position  = position_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_step_position_ctrl.sv
// Bench for step_position_ctrl: randomized moves scored against an event-level
// model of when each step and done pulse must appear and what position they carry.
module tb_step_position_ctrl;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_steps;
    logic [23:0] cmd_period;
    logic        abort;
    logic        pos_clear;
    logic        step;
    logic        dir;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [31:0] position;
    logic [1:0]  dbg_state;

    logic        s_cmd_valid;
    logic        s_cmd_ready;
    logic [3:0]  s_cmd_steps;
    logic [3:0]  s_cmd_period;
    logic        s_abort;
    logic        s_pos_clear;
    logic        s_step;
    logic        s_dir;
    logic        s_busy;
    logic        s_done;
    logic        s_aborted;
    logic [3:0]  s_position;
    logic [1:0]  s_dbg_state;

    typedef struct packed {
        logic        is_done;
        logic        aborted;
        logic        dir;
        logic [31:0] cycle;
        logic [31:0] pos;
    } exp_t;
    localparam int EXP_W = $bits(exp_t);

    logic [EXP_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_err    = 0;
    int edge_cnt = 0;
    int m_pos    = 0;
    bit m_dir    = 1'b0;
    int s_pos_m  = 0;

    step_position_ctrl dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_steps(cmd_steps), .cmd_period(cmd_period), .abort(abort),
        .pos_clear(pos_clear), .step(step), .dir(dir), .busy(busy), .done(done),
        .aborted(aborted), .position(position), .dbg_state(dbg_state)
    );

    step_position_ctrl #(.COUNT_W(4), .PERIOD_W(4), .POS_W(4)) dut_small (
        .clk(clk), .rst(rst), .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready),
        .cmd_steps(s_cmd_steps), .cmd_period(s_cmd_period), .abort(s_abort),
        .pos_clear(s_pos_clear), .step(s_step), .dir(s_dir), .busy(s_busy), .done(s_done),
        .aborted(s_aborted), .position(s_position), .dbg_state(s_dbg_state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_cnt);
        end
    endtask

    // Scoreboard monitor: every step or done pulse consumes one expected event.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (step || done) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL unexpected_output: step=%0b done=%0b at edge %0d, expected no output",
                             step, done, edge_cnt);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind_done", {63'b0, done}, {63'b0, e.is_done});
                    check("event_kind_step", {63'b0, step}, {63'b0, !e.is_done});
                    check("event_edge", 64'(edge_cnt), {32'b0, e.cycle});
                    check("event_position", {32'b0, position}, {32'b0, e.pos});
                    check("event_dir", {63'b0, dir}, {63'b0, e.dir});
                    check("event_aborted", {63'b0, aborted}, {63'b0, e.aborted});
                end
            end else if (aborted) begin
                check("aborted_without_done", {63'b0, aborted}, 64'd0);
            end
        end
    end

    task automatic push_exp(input bit is_done, input bit ab, input int cyc, input int pos);
        exp_t e;
        e.is_done = is_done;
        e.aborted = ab;
        e.dir     = m_dir;
        e.cycle   = cyc;
        e.pos     = pos;
        exp_q.push_back(e);
    endtask

    // Driver: must be entered at a negedge with the DUT idle; returns at the
    // negedge right after the acceptance edge. abort_at is edges after acceptance (0 = none).
    task automatic issue_cmd(input int steps, input int period, input bit clr, input int abort_at);
        int p, n, e0, fired;
        bit eff;
        cmd_valid  = 1'b1;
        cmd_steps  = 16'(steps);
        cmd_period = 24'(period);
        pos_clear  = clr;
        #1;
        check("cmd_ready_idle", {63'b0, cmd_ready}, 64'd1);
        e0 = edge_cnt + 1;
        if (clr) m_pos = 0;
        p = (period < 2) ? 2 : period;
        n = (steps < 0) ? -steps : steps;
        if (n == 0) begin
            push_exp(1'b1, 1'b0, e0, m_pos);
        end else begin
            m_dir = (steps > 0);
            eff   = (abort_at != 0) && (abort_at <= n * p);
            fired = eff ? (abort_at - 1) / p : n;
            for (int k = 1; k <= fired; k++) begin
                m_pos = m_pos + (m_dir ? 1 : -1);
                push_exp(1'b0, 1'b0, e0 + k * p, m_pos);
            end
            push_exp(1'b1, eff, eff ? e0 + abort_at : e0 + n * p + 1, m_pos);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        pos_clear = 1'b0;
    endtask

    task automatic wait_idle(input int e0, input int abort_at);
        for (int t = 0; t < 5000; t++) begin
            if (!busy) break;
            abort     = (abort_at != 0) && (edge_cnt + 1 == e0 + abort_at);
            pos_clear = ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        abort     = 1'b0;
        pos_clear = 1'b0;
        check("idle_timeout_busy", {63'b0, busy}, 64'd0);
    endtask

    task automatic run_cmd(input int steps, input int period, input bit clr, input int abort_at);
        int e0;
        e0 = edge_cnt + 1;
        issue_cmd(steps, period, clr, abort_at);
        wait_idle(e0, abort_at);
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic s_move(input int steps, input int period);
        int p, n, e0, k;
        bit d;
        p = (period < 2) ? 2 : period;
        n = (steps < 0) ? -steps : steps;
        d = (steps > 0);
        s_cmd_valid  = 1'b1;
        s_cmd_steps  = 4'(steps);
        s_cmd_period = 4'(period);
        #1;
        check("s_cmd_ready", {63'b0, s_cmd_ready}, 64'd1);
        e0 = edge_cnt + 1;
        @(negedge clk);
        s_cmd_valid = 1'b0;
        k = 0;
        for (int t = 0; t < 200; t++) begin
            if (s_done) break;
            if (s_step) begin
                k++;
                s_pos_m = s_pos_m + (d ? 1 : -1);
                check("s_step_edge", 64'(edge_cnt), 64'(e0 + k * p));
                check("s_step_position", {60'b0, s_position}, {60'b0, 4'(s_pos_m)});
            end
            @(negedge clk);
        end
        check("s_step_count", 64'(k), 64'(n));
        check("s_done", {63'b0, s_done}, 64'd1);
        check("s_dir", {63'b0, s_dir}, {63'b0, d});
        check("s_final_position", {60'b0, s_position}, {60'b0, 4'(s_pos_m)});
        @(negedge clk);
    endtask

    initial begin
        int steps, period, n, p, ab, e0;
        bit clr;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_steps = '0; cmd_period = '0; abort = 1'b0; pos_clear = 1'b0;
        s_cmd_valid = 1'b0; s_cmd_steps = '0; s_cmd_period = '0; s_abort = 1'b0; s_pos_clear = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_cmd_ready", {63'b0, cmd_ready}, 64'd0);
        check("reset_outputs", {59'b0, step, dir, busy, done, aborted}, 64'd0);
        check("reset_position", {32'b0, position}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed moves from the reference scenarios
        run_cmd(3, 4, 1'b0, 0);
        check("pos_after_plus3", {32'b0, position}, 64'd3);
        check("dir_after_plus3", {63'b0, dir}, 64'd1);
        run_cmd(-5, 0, 1'b0, 0);
        check("pos_after_minus5", {32'b0, position}, {32'b0, 32'hFFFF_FFFE});
        check("dir_after_minus5", {63'b0, dir}, 64'd0);
        run_cmd(0, 7, 1'b0, 0);
        check("dir_after_zero", {63'b0, dir}, 64'd0);
        run_cmd(10, 3, 1'b0, 12);
        check("pos_after_abort", {32'b0, position}, 64'd1);

        abort = 1'b1;
        #1;
        check("abort_idle_blocks_ready", {63'b0, cmd_ready}, 64'd0);
        abort = 1'b0;
        #1;
        check("ready_after_abort_idle", {63'b0, cmd_ready}, 64'd1);
        @(negedge clk);

        pos_clear = 1'b1;
        @(negedge clk);
        pos_clear = 1'b0;
        m_pos = 0;
        check("pos_clear_idle", {32'b0, position}, 64'd0);

        // Randomized moves
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 9) == 0) steps = 0;
            else steps = $urandom_range(1, 8) * (($urandom_range(0, 1) == 1) ? 1 : -1);
            period = $urandom_range(0, 5);
            clr    = ($urandom_range(0, 3) == 0);
            p = (period < 2) ? 2 : period;
            n = (steps < 0) ? -steps : steps;
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n * p + 2) : 0;
            run_cmd(steps, period, clr, ab);
        end

        // Reset in the middle of a move discards it
        e0 = edge_cnt + 1;
        issue_cmd(20, 3, 1'b0, 0);
        repeat (7) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        exp_q.delete();
        m_pos = 0;
        m_dir = 1'b0;
        check("midreset_outputs", {59'b0, step, dir, busy, done, aborted}, 64'd0);
        check("midreset_position", {32'b0, position}, 64'd0);
        check("midreset_cmd_ready", {63'b0, cmd_ready}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("after_reset_idle", {62'b0, busy, done}, 64'd0);
        run_cmd(2, 2, 1'b0, 0);

        // Narrow instance: magnitude of the most negative count and position wrap
        s_pos_m = 0;
        s_move(-5, 2);
        s_move(-8, 2);
        s_move(7, 1);

        repeat (3) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
